// File: rtl/gemm_mac_engine_pkg.sv
// Shared types and derived widths for the int8 GEMM MAC engine.
// Optional zero-point support is selected with the GEMM_ZERO_POINT_EN macro.
package gemm_mac_engine_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam int unsigned LANES      = 8;
  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ACC_WIDTH  = 32;
  localparam int unsigned ADDR_WIDTH = 13;

  // Zero-point subtraction widens each operand by one bit, so the product gains two.
  function automatic int unsigned prod_width(input int unsigned dw);
`ifdef GEMM_ZERO_POINT_EN
    return 2 * dw + 2;
`else
    return 2 * dw;
`endif
  endfunction

  localparam int unsigned PROD_W = prod_width(DATA_WIDTH);
  localparam int unsigned SUM_W  = PROD_W + $clog2(LANES);
  localparam int unsigned VEC_W  = LANES * DATA_WIDTH;

endpackage

// File: rtl/gemm_mac_engine_if.sv
// Command, operand-stream and result-stream bundle of the GEMM MAC engine.
// With GEMM_ZERO_POINT_EN the per-command zero points a_zp/b_zp are added.
interface gemm_mac_engine_if #(
  parameter int unsigned Lanes     = gemm_mac_engine_pkg::LANES,
  parameter int unsigned DataWidth = gemm_mac_engine_pkg::DATA_WIDTH,
  parameter int unsigned AccWidth  = gemm_mac_engine_pkg::ACC_WIDTH,
  parameter int unsigned AddrWidth = gemm_mac_engine_pkg::ADDR_WIDTH
);

  logic                          start;
  logic [AddrWidth-1:0]          cfg_m;
  logic [AddrWidth-1:0]          cfg_n;
  logic [AddrWidth-1:0]          cfg_k_beats;
  logic                          in_valid;
  logic                          in_ready;
  logic [Lanes*DataWidth-1:0]    data_in;
  logic [Lanes*DataWidth-1:0]    weight_in;
  logic                          out_valid;
  logic                          out_ready;
  logic signed [AccWidth-1:0]    mac_out;
  logic [AddrWidth-1:0]          out_row;
  logic [AddrWidth-1:0]          out_col;
  logic                          busy;
  logic                          done;
`ifdef GEMM_ZERO_POINT_EN
  logic signed [DataWidth-1:0]   a_zp;
  logic signed [DataWidth-1:0]   b_zp;
`endif

  modport slave (
`ifdef GEMM_ZERO_POINT_EN
    input  a_zp, b_zp,
`endif
    input  start, cfg_m, cfg_n, cfg_k_beats, in_valid, data_in, weight_in, out_ready,
    output in_ready, out_valid, mac_out, out_row, out_col, busy, done
  );

  modport master (
`ifdef GEMM_ZERO_POINT_EN
    output a_zp, b_zp,
`endif
    output start, cfg_m, cfg_n, cfg_k_beats, in_valid, data_in, weight_in, out_ready,
    input  in_ready, out_valid, mac_out, out_row, out_col, busy, done
  );

endinterface

// File: rtl/gemm_adder_tree.sv
// Combinational signed LANES->1 reduction; output grows by log2(Lanes) bits.
module gemm_adder_tree #(
  parameter int unsigned Lanes = 8,
  parameter int unsigned InW   = 16
) (
  input  logic [Lanes*InW-1:0]                    in_i,
  output logic signed [InW+$clog2(Lanes)-1:0]     sum_o
);

  localparam int unsigned OutW = InW + $clog2(Lanes);

  logic signed [OutW-1:0] node [Lanes];

  // Pairwise halving in place: each level reads indices >= the one it writes.
  always_comb begin
    for (int i = 0; i < Lanes; i++) begin
      node[i] = OutW'($signed(in_i[i*InW +: InW]));
    end
    for (int w = Lanes / 2; w >= 1; w = w / 2) begin
      for (int i = 0; i < w; i++) begin
        node[i] = node[2*i] + node[2*i+1];
      end
    end
    sum_o = node[0];
  end

endmodule

// File: rtl/gemm_mac_engine.sv
// Int8 GEMM tile engine: LANES multipliers -> adder tree -> accumulator -> tagged results.
// Optional zero-point correction is enabled by defining GEMM_ZERO_POINT_EN.
module gemm_mac_engine
  import gemm_mac_engine_pkg::*;
#(
  parameter int unsigned Lanes     = LANES,
  parameter int unsigned DataWidth = DATA_WIDTH,
  parameter int unsigned AccWidth  = ACC_WIDTH,
  parameter int unsigned AddrWidth = ADDR_WIDTH
) (
  input logic             clk,
  input logic             rst,
  gemm_mac_engine_if.slave io
);

  localparam int unsigned ProdW = prod_width(DataWidth);
  localparam int unsigned SumW  = ProdW + $clog2(Lanes);
  localparam logic [AddrWidth-1:0] One = AddrWidth'(1);

  state_e state_q, state_d;
  logic [AddrWidth-1:0] m_q, m_d, n_q, n_d, kb_q, kb_d;
  logic [AddrWidth-1:0] in_k_q, in_k_d, in_col_q, in_col_d, in_row_q, in_row_d;
  logic                 in_all_q, in_all_d;
  logic                 s1_v_q, s1_v_d, s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  logic [Lanes*ProdW-1:0] prod_q, prod_d, lane_prod;
  logic signed [SumW-1:0]     tree_sum;
  logic signed [AccWidth-1:0] sum_ext, acc_next, acc_q, acc_d, mac_q, mac_d;
  logic                 out_v_q, out_v_d;
  logic [AddrWidth-1:0] out_row_q, out_row_d, out_col_q, out_col_d;
`ifdef GEMM_ZERO_POINT_EN
  logic signed [DataWidth-1:0] a_zp_q, a_zp_d, b_zp_q, b_zp_d;
`endif

  logic stall, in_ready, in_fire, out_fire, cmd_go, cfg_zero, out_last;

  assign stall    = out_v_q & ~io.out_ready;
  assign in_ready = (state_q == StRun) & ~stall & ~in_all_q;
  assign in_fire  = io.in_valid & in_ready;
  assign out_fire = out_v_q & io.out_ready;
  assign cmd_go   = (state_q == StIdle) & io.start;
  assign cfg_zero = (io.cfg_m == '0) | (io.cfg_n == '0) | (io.cfg_k_beats == '0);
  assign out_last = out_fire & (out_row_q == m_q - One) & (out_col_q == n_q - One);

  for (genvar l = 0; l < Lanes; l++) begin : g_lane
    logic signed [DataWidth-1:0] a_l, b_l;
    assign a_l = io.data_in[l*DataWidth +: DataWidth];
    assign b_l = io.weight_in[l*DataWidth +: DataWidth];
`ifdef GEMM_ZERO_POINT_EN
    localparam int unsigned OpW = DataWidth + 1;
    logic signed [OpW-1:0] a_o, b_o;
    assign a_o = OpW'(a_l) - OpW'(a_zp_q);
    assign b_o = OpW'(b_l) - OpW'(b_zp_q);
`else
    logic signed [DataWidth-1:0] a_o, b_o;
    assign a_o = a_l;
    assign b_o = b_l;
`endif
    assign lane_prod[l*ProdW +: ProdW] = ProdW'(a_o) * ProdW'(b_o);
  end

  gemm_adder_tree #(
    .Lanes (Lanes),
    .InW   (ProdW)
  ) u_tree (
    .in_i  (prod_q),
    .sum_o (tree_sum)
  );

  assign sum_ext  = AccWidth'(tree_sum);
  assign acc_next = s1_first_q ? sum_ext : acc_q + sum_ext;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (io.start) state_d = cfg_zero ? StDone : StRun;
      StRun:   if (out_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    m_d        = m_q;
    n_d        = n_q;
    kb_d       = kb_q;
    in_k_d     = in_k_q;
    in_col_d   = in_col_q;
    in_row_d   = in_row_q;
    in_all_d   = in_all_q;
    s1_v_d     = s1_v_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    prod_d     = prod_q;
    acc_d      = acc_q;
    mac_d      = mac_q;
    out_v_d    = out_v_q;
    out_row_d  = out_row_q;
    out_col_d  = out_col_q;
`ifdef GEMM_ZERO_POINT_EN
    a_zp_d     = a_zp_q;
    b_zp_d     = b_zp_q;
    if (cmd_go) begin
      a_zp_d = io.a_zp;
      b_zp_d = io.b_zp;
    end
`endif
    if (cmd_go) begin
      m_d       = io.cfg_m;
      n_d       = io.cfg_n;
      kb_d      = io.cfg_k_beats;
      in_k_d    = '0;
      in_col_d  = '0;
      in_row_d  = '0;
      in_all_d  = 1'b0;
      out_row_d = '0;
      out_col_d = '0;
    end
    // Input-side walk over (row, col, k) only gates in_ready once every beat is in.
    if (in_fire) begin
      if (in_k_q == kb_q - One) begin
        in_k_d = '0;
        if (in_col_q == n_q - One) begin
          in_col_d = '0;
          if (in_row_q == m_q - One) in_all_d = 1'b1;
          else                       in_row_d = in_row_q + One;
        end else begin
          in_col_d = in_col_q + One;
        end
      end else begin
        in_k_d = in_k_q + One;
      end
    end
    if (!stall) begin
      s1_v_d = in_fire;
      if (in_fire) begin
        prod_d     = lane_prod;
        s1_first_d = (in_k_q == '0);
        s1_last_d  = (in_k_q == kb_q - One);
      end
    end
    if (out_fire) begin
      out_v_d = 1'b0;
      if (out_col_q == n_q - One) begin
        out_col_d = '0;
        out_row_d = (out_row_q == m_q - One) ? '0 : out_row_q + One;
      end else begin
        out_col_d = out_col_q + One;
      end
    end
    // A held output slot blocks stage 2, so a new result only lands after the old one left.
    if (!stall && s1_v_q) begin
      acc_d = acc_next;
      if (s1_last_q) begin
        mac_d   = acc_next;
        out_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      m_q        <= '0;
      n_q        <= '0;
      kb_q       <= '0;
      in_k_q     <= '0;
      in_col_q   <= '0;
      in_row_q   <= '0;
      in_all_q   <= 1'b0;
      s1_v_q     <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
      mac_q      <= '0;
      out_v_q    <= 1'b0;
      out_row_q  <= '0;
      out_col_q  <= '0;
`ifdef GEMM_ZERO_POINT_EN
      a_zp_q     <= '0;
      b_zp_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      n_q        <= n_d;
      kb_q       <= kb_d;
      in_k_q     <= in_k_d;
      in_col_q   <= in_col_d;
      in_row_q   <= in_row_d;
      in_all_q   <= in_all_d;
      s1_v_q     <= s1_v_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      prod_q     <= prod_d;
      acc_q      <= acc_d;
      mac_q      <= mac_d;
      out_v_q    <= out_v_d;
      out_row_q  <= out_row_d;
      out_col_q  <= out_col_d;
`ifdef GEMM_ZERO_POINT_EN
      a_zp_q     <= a_zp_d;
      b_zp_q     <= b_zp_d;
`endif
    end
  end

  assign io.in_ready  = in_ready;
  assign io.out_valid = out_v_q;
  assign io.mac_out   = mac_q;
  assign io.out_row   = out_row_q;
  assign io.out_col   = out_col_q;
  assign io.busy      = (state_q != StIdle);
  assign io.done      = (state_q == StDone);

endmodule

// File: tb/tb_gemm_mac_engine.sv
// Scoreboard bench for gemm_mac_engine: directed tiles, backpressure, zero-size, reset abort.
// Zero-point vectors run only when GEMM_ZERO_POINT_EN is defined.
module tb_gemm_mac_engine;

  localparam int unsigned Lanes = 8;
  localparam int unsigned Dw    = 8;
  localparam int unsigned Aw    = 32;
  localparam int unsigned Adw   = 13;

  typedef struct packed {
    logic [31:0] val;
    logic [12:0] row;
    logic [12:0] col;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  int   n_exp  = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  gemm_mac_engine_if #(
    .Lanes(Lanes), .DataWidth(Dw), .AccWidth(Aw), .AddrWidth(Adw)
  ) io ();

  gemm_mac_engine #(
    .Lanes(Lanes), .DataWidth(Dw), .AccWidth(Aw), .AddrWidth(Adw)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, $signed(act), $signed(req));
    end
  endtask

  // Monitor: every accepted result is compared against the head of the queue.
  always @(negedge clk) begin
    if (!rst && io.out_valid && io.out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0d required=none", io.mac_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result_val", 32'(io.mac_out), mon_e.val);
        chk("result_row", 32'(io.out_row), 32'(mon_e.row));
        chk("result_col", 32'(io.out_col), 32'(mon_e.col));
      end
    end
  end

  task automatic expect_res(input int v, input int r, input int c);
    exp_t e;
    e.val = 32'(v);
    e.row = 13'(r);
    e.col = 13'(c);
    exp_q.push_back(e);
    n_exp++;
  endtask

  function automatic logic [63:0] splat(input int v);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = 8'(v);
    return r;
  endfunction

  function automatic logic [63:0] lane0(input int v0, input int rest);
    logic [63:0] r;
    r = splat(rest);
    r[7:0] = 8'(v0);
    return r;
  endfunction

  // Called and returns at posedge+1.
  task automatic cmd(input int m, input int n, input int kb);
    io.start       = 1'b1;
    io.cfg_m       = 13'(m);
    io.cfg_n       = 13'(n);
    io.cfg_k_beats = 13'(kb);
    @(posedge clk); #1;
    io.start = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] a, input logic [63:0] b);
    int g;
    g = 0;
    io.in_valid  = 1'b1;
    io.data_in   = a;
    io.weight_in = b;
    @(negedge clk);
    while (!io.in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!io.in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout actual=in_ready_low required=in_ready_high");
    end
    @(posedge clk); #1;
    io.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int g;
    g = 0;
    while (!io.done && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk({name, "_done_seen"}, 32'(io.done), 32'd1);
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, 32'(io.done), 32'd0);
    chk({name, "_busy_low"}, 32'(io.busy), 32'd0);
  endtask

  // Element v of the 2x2xK2 tile: 8 from beat 0, v-8 from beat 1.
  task automatic send_tile_2x2();
    for (int v = 1; v <= 4; v++) begin
      expect_res(v, (v - 1) / 2, (v - 1) % 2);
      send_beat(splat(1), splat(1));
      send_beat(lane0(v - 8, 0), lane0(1, 5));
    end
  endtask

  task automatic stall_test();
    int base;
    logic [31:0] cap_mac, cap_row, cap_col;
    base = n_out;
    cmd(2, 2, 2);
    fork
      send_tile_2x2();
      begin
        int g;
        g = 0;
        while (n_out < base + 1 && g < 200) begin
          @(posedge clk); #1;
          g++;
        end
        io.out_ready = 1'b0;
        g = 0;
        while (!io.out_valid && g < 50) begin
          @(posedge clk); #1;
          g++;
        end
        chk("t3_stall_valid", 32'(io.out_valid), 32'd1);
        cap_mac = 32'(io.mac_out);
        cap_row = 32'(io.out_row);
        cap_col = 32'(io.out_col);
        chk("t3_held_val", cap_mac, 32'd2);
        chk("t3_held_col", cap_col, 32'd1);
        repeat (5) begin
          @(posedge clk); #1;
          chk("t3_in_ready_low", 32'(io.in_ready), 32'd0);
          chk("t3_valid_held", 32'(io.out_valid), 32'd1);
          chk("t3_mac_stable", 32'(io.mac_out), cap_mac);
          chk("t3_row_stable", 32'(io.out_row), cap_row);
          chk("t3_col_stable", 32'(io.out_col), cap_col);
        end
        io.out_ready = 1'b1;
      end
    join
    wait_done("t3");
  endtask

  initial begin
    int g;
    io.start       = 1'b0;
    io.cfg_m       = '0;
    io.cfg_n       = '0;
    io.cfg_k_beats = '0;
    io.in_valid    = 1'b0;
    io.data_in     = '0;
    io.weight_in   = '0;
    io.out_ready   = 1'b1;
`ifdef GEMM_ZERO_POINT_EN
    io.a_zp        = '0;
    io.b_zp        = '0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(io.in_ready), 32'd0);
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_mac", 32'(io.mac_out), 32'd0);
    chk("rst_busy", 32'(io.busy), 32'd0);
    chk("rst_done", 32'(io.done), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1x1, K=1 beat: 8 lanes of 3*-2.
    cmd(1, 1, 1);
    chk("t1_busy", 32'(io.busy), 32'd1);
    expect_res(-48, 0, 0);
    send_beat(splat(3), splat(-2));
    chk("t1_lat_early", 32'(io.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("t1_lat_2cyc", 32'(io.out_valid), 32'd1);
    @(posedge clk); #1;
    chk("t1_done", 32'(io.done), 32'd1);
    chk("t1_busy_in_done", 32'(io.busy), 32'd1);
    @(posedge clk); #1;
    chk("t1_done_pulse", 32'(io.done), 32'd0);
    chk("t1_busy_low", 32'(io.busy), 32'd0);

    // 2x2 tile, 2 beats per element.
    cmd(2, 2, 2);
    send_tile_2x2();
    wait_done("t2");

    // Same tile with the second result held for 5 cycles.
    stall_test();

    // Zero-size command: straight to done; start held into DONE must not relaunch.
    io.start       = 1'b1;
    io.cfg_m       = 13'd2;
    io.cfg_n       = 13'd0;
    io.cfg_k_beats = 13'd1;
    @(posedge clk); #1;
    chk("t4_done", 32'(io.done), 32'd1);
    chk("t4_no_valid", 32'(io.out_valid), 32'd0);
    @(posedge clk); #1;
    io.start = 1'b0;
    chk("t4_done_pulse", 32'(io.done), 32'd0);
    chk("t4_busy_low", 32'(io.busy), 32'd0);
    @(posedge clk); #1;
    chk("t4_still_idle", 32'(io.busy), 32'd0);

    // Start during RUN with a zero config must be ignored.
    cmd(1, 1, 1);
    cmd(0, 1, 1);
    chk("t4_run_ignore_busy", 32'(io.busy), 32'd1);
    chk("t4_run_ignore_done", 32'(io.done), 32'd0);
    expect_res(-32, 0, 0);
    send_beat(splat(-1), splat(4));
    wait_done("t4");

    // Reset mid-RUN after 3 beats, with the first result parked at the output.
    io.out_ready = 1'b0;
    cmd(2, 2, 2);
    repeat (3) send_beat(splat(1), splat(1));
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_out_valid", 32'(io.out_valid), 32'd0);
    chk("t5_in_ready", 32'(io.in_ready), 32'd0);
    chk("t5_mac", 32'(io.mac_out), 32'd0);
    chk("t5_row", 32'(io.out_row), 32'd0);
    chk("t5_col", 32'(io.out_col), 32'd0);
    chk("t5_busy", 32'(io.busy), 32'd0);
    chk("t5_done", 32'(io.done), 32'd0);
    rst = 1'b0;
    io.out_ready = 1'b1;
    @(posedge clk); #1;
    cmd(1, 1, 1);
    expect_res(112, 0, 0);
    send_beat(splat(7), splat(2));
    wait_done("t5");

`ifdef GEMM_ZERO_POINT_EN
    // (1-1)*(-1+1)=0 per lane; (5-1)*(1+1)=8 per lane -> 64.
    io.a_zp = 8'sd1;
    io.b_zp = -8'sd1;
    cmd(1, 2, 1);
    io.a_zp = '0;
    io.b_zp = '0;
    expect_res(0, 0, 0);
    send_beat(splat(1), splat(-1));
    expect_res(64, 0, 1);
    send_beat(splat(5), splat(1));
    wait_done("t6");
`endif

    g = 0;
    while (exp_q.size() != 0 && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    chk("result_count", 32'(n_out), 32'(n_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
